// File: rtl/serial_link_uart.sv
// 8N1 UART with independent transmitter and receiver, CLKS_PER_BIT clocks per bit.
// The transmitter is started by a rising edge on load; the receiver samples at mid-bit.
module serial_link_uart #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] transmit,
  input  logic       transmitenable,
  input  logic       load,
  output logic       charsent,
  output logic [7:0] receive,
  output logic       charrcvd,
  output logic       frame_error,
  output logic       tx,
  input  logic       rx
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        load_q;
  logic        tx_armed;
  logic        tx_accept;

  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_meta;
  logic        rxs;

  // tx_armed blocks the first cycle after reset so a load held high through
  // reset release is seen as a level, not as a fresh edge.
  assign tx_accept = load & ~load_q & transmitenable & tx_armed & (tx_state == TX_IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values and the order of statements inside the block is irrelevant.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      load_q   <= 1'b0;
      tx_armed <= 1'b0;
      tx       <= 1'b1;
      charsent <= 1'b1;
    end else begin
      load_q   <= load;
      tx_armed <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_shift <= transmit;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            charsent <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            charsent <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      receive     <= 8'h00;
      charrcvd    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_cnt   <= '0;
            charrcvd <= 1'b0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start-bit recheck rejects glitches shorter than half a bit.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rxs) begin
              receive     <= rx_shift;
              charrcvd    <= 1'b1;
              frame_error <= 1'b0;
              rx_state    <= RX_IDLE;
            end else begin
              frame_error <= 1'b1;
              rx_state    <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_uart.sv
// Directed self-checking bench for serial_link_uart at CLKS_PER_BIT = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_link_uart;

  localparam int CPB = 4;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [7:0] transmit;
  logic       transmitenable;
  logic       load;
  logic       charsent;
  logic [7:0] receive;
  logic       charrcvd;
  logic       frame_error;
  logic       tx;
  logic       rx_drv;
  logic       loopback;
  logic       rx_line;

  int checks = 0;
  int errors = 0;

  assign rx_line = loopback ? tx : rx_drv;

  serial_link_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .transmit       (transmit),
    .transmitenable (transmitenable),
    .load           (load),
    .charsent       (charsent),
    .receive        (receive),
    .charrcvd       (charrcvd),
    .frame_error    (frame_error),
    .tx             (tx),
    .rx             (rx_line)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Starts a frame with a load edge and checks every cycle of tx and charsent.
  // reload_at: cycle of a second load edge (with transmit=alt) inside the frame.
  // te_drop_at: cycle at which transmitenable is dropped inside the frame.
  task automatic tx_frame_check(input logic [7:0] data, input int reload_at,
                                input logic [7:0] alt, input int te_drop_at,
                                input string tag);
    logic exp_tx;
    transmit = data;
    load     = 1'b1;
    @(negedge clk_clk);
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k < CPB)           exp_tx = 1'b0;
      else if (k < 9 * CPB)  exp_tx = data[(k - CPB) / CPB];
      else                   exp_tx = 1'b1;
      checks++;
      if (tx !== exp_tx) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", tag, k, tx, exp_tx);
      end
      checks++;
      if (charsent !== 1'b0) begin
        errors++;
        $display("FAIL %s charsent busy cycle %0d: got %b expected 0", tag, k, charsent);
      end
      if (k == reload_at - 2) load = 1'b0;
      if (k == reload_at) begin
        transmit = alt;
        load     = 1'b1;
      end
      if (k == te_drop_at) transmitenable = 1'b0;
      @(negedge clk_clk);
    end
    checks++;
    if (charsent !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s frame end: charsent=%b tx=%b expected 1 1", tag, charsent, tx);
    end
    load           = 1'b0;
    transmitenable = 1'b1;
  endtask

  task automatic drive_rx_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (CPB) @(negedge clk_clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_rx(input logic [7:0] exp_rcv, input logic exp_rcvd,
                          input logic exp_fe, input string tag);
    checks++;
    if (receive !== exp_rcv || charrcvd !== exp_rcvd || frame_error !== exp_fe) begin
      errors++;
      $display("FAIL %s: receive=%h charrcvd=%b frame_error=%b expected %h %b %b",
               tag, receive, charrcvd, frame_error, exp_rcv, exp_rcvd, exp_fe);
    end
  endtask

  task automatic test_reset;
    reset_reset    = 1'b1;
    transmit       = 8'h00;
    transmitenable = 1'b0;
    load           = 1'b0;
    rx_drv         = 1'b1;
    loopback       = 1'b0;
    repeat (3) @(negedge clk_clk);
    checks++;
    if (tx !== 1'b1 || charsent !== 1'b1) begin
      errors++;
      $display("FAIL reset tx side: tx=%b charsent=%b expected 1 1", tx, charsent);
    end
    check_rx(8'h00, 1'b0, 1'b0, "reset rx side");
    reset_reset = 1'b0;
    repeat (2) @(negedge clk_clk);
  endtask

  task automatic test_tx_basic;
    transmitenable = 1'b1;
    tx_frame_check(8'hA5, 8, 8'h3C, -1, "tx_a5_ignore_reload");
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tx !== 1'b1 || charsent !== 1'b1) begin
        errors++;
        $display("FAIL no_queued_frame cycle %0d: tx=%b charsent=%b expected 1 1", i, tx, charsent);
      end
      @(negedge clk_clk);
    end
  endtask

  task automatic test_tx_enable;
    transmitenable = 1'b0;
    load           = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_clk);
      checks++;
      if (tx !== 1'b1 || charsent !== 1'b1) begin
        errors++;
        $display("FAIL te_low_no_start cycle %0d: tx=%b charsent=%b expected 1 1", i, tx, charsent);
      end
    end
    load           = 1'b0;
    transmitenable = 1'b1;
    @(negedge clk_clk);
    tx_frame_check(8'h81, -100, 8'h00, 12, "tx_81_te_drop");
    repeat (2) @(negedge clk_clk);
  endtask

  task automatic test_rx_valid;
    drive_rx_frame(8'h5A, 1'b1);
    repeat (6) @(negedge clk_clk);
    check_rx(8'h5A, 1'b1, 1'b0, "rx_valid_5a");
  endtask

  task automatic test_rx_frame_error;
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk_clk);
    check_rx(8'h5A, 1'b0, 1'b0, "charrcvd_clear_at_start");
    rx_drv = 1'b1;
    repeat (8 * CPB) @(negedge clk_clk);
    rx_drv = 1'b0;
    repeat (CPB + 16) @(negedge clk_clk);
    check_rx(8'h5A, 1'b0, 1'b1, "rx_bad_stop_held_low");
    rx_drv = 1'b1;
    repeat (30) @(negedge clk_clk);
    check_rx(8'h5A, 1'b0, 1'b1, "rx_bad_stop_after_high");
  endtask

  task automatic test_rx_glitch;
    rx_drv = 1'b0;
    @(negedge clk_clk);
    rx_drv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_clk);
      check_rx(8'h5A, 1'b0, 1'b1, "rx_glitch_no_change");
    end
    drive_rx_frame(8'h96, 1'b1);
    repeat (6) @(negedge clk_clk);
    check_rx(8'h96, 1'b1, 1'b0, "rx_valid_96_after_error");
  endtask

  task automatic test_loopback;
    loopback = 1'b1;
    @(negedge clk_clk);
    tx_frame_check(8'hC3, -100, 8'h00, -1, "tx_c3_loopback");
    repeat (8) @(negedge clk_clk);
    check_rx(8'hC3, 1'b1, 1'b0, "rx_loopback_c3");
    loopback = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic test_reset_midframe;
    transmitenable = 1'b1;
    transmit       = 8'h55;
    load           = 1'b1;
    @(negedge clk_clk);
    repeat (20) @(negedge clk_clk);
    checks++;
    if (charsent !== 1'b0) begin
      errors++;
      $display("FAIL midframe_busy: charsent=%b expected 0", charsent);
    end
    reset_reset = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (tx !== 1'b1 || charsent !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: tx=%b charsent=%b expected 1 1", tx, charsent);
    end
    check_rx(8'h00, 1'b0, 1'b0, "reset_clears_rx");
    reset_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_clk);
      checks++;
      if (tx !== 1'b1 || charsent !== 1'b1) begin
        errors++;
        $display("FAIL load_held_through_reset cycle %0d: tx=%b charsent=%b expected 1 1",
                 i, tx, charsent);
      end
    end
    load = 1'b0;
    @(negedge clk_clk);
    load = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (tx !== 1'b0 || charsent !== 1'b0) begin
      errors++;
      $display("FAIL fresh_load_starts: tx=%b charsent=%b expected 0 0", tx, charsent);
    end
    repeat (10 * CPB) @(negedge clk_clk);
    checks++;
    if (tx !== 1'b1 || charsent !== 1'b1) begin
      errors++;
      $display("FAIL fresh_frame_done: tx=%b charsent=%b expected 1 1", tx, charsent);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_enable();
    test_rx_valid();
    test_rx_frame_error();
    test_rx_glitch();
    test_loopback();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
